// File: rtl/payload_receiver_pkg.sv
// Event codes shared by the inbound/outbound payload paths, plus receiver FSM state type.
package payload_receiver_pkg;

  localparam logic [7:0] EVENT_GAME_STATUS = 8'hAD;
  localparam logic [7:0] EVENT_CMD_C1      = 8'hC1;
  localparam logic [7:0] EVENT_CMD_C2      = 8'hC2;
  localparam logic [7:0] EVENT_CMD_C3      = 8'hC3;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_RECEIVING = 1'b1
  } rx_state_e;

endpackage

// File: rtl/payload_receiver_if.sv
// Byte stream from the UART RX core in, assembled payload and status pulses out.
interface payload_receiver_if #(
  parameter int RECV_BYTES_QTD = 4
);

  logic [7:0]                  dado_recebido;
  logic                        dado_valido;
  logic [RECV_BYTES_QTD*8-1:0] buffer_recebido;
  logic                        pacote_pronto;
  logic                        erro_timeout;
  logic                        ocupado;

  modport master (
    output dado_recebido,
    output dado_valido,
    input  buffer_recebido,
    input  pacote_pronto,
    input  erro_timeout,
    input  ocupado
  );

  modport slave (
    input  dado_recebido,
    input  dado_valido,
    output buffer_recebido,
    output pacote_pronto,
    output erro_timeout,
    output ocupado
  );

endinterface

// File: rtl/payload_receiver_inter_byte_timer.sv
// Counts idle cycles between bytes; expired_o flags the cycle whose edge ends the allowed gap.
// Saturating counter, so a stalled enable never wraps back into a false restart.
module payload_receiver_inter_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (enable_i && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired_o = enable_i && (timer_q == TIMER_LAST);

endmodule

// File: rtl/payload_receiver.sv
// Waits for EVENT_CODE, then gathers RECV_BYTES_QTD payload bytes into buffer_recebido (first byte in MSBs).
// Partial packets are dropped when the inter-byte gap reaches TIMEOUT_CYCLES.
module payload_receiver
  import payload_receiver_pkg::*;
#(
  parameter logic [7:0] EVENT_CODE     = EVENT_CMD_C1,
  parameter int         RECV_BYTES_QTD = 4,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset,
  payload_receiver_if.slave  rx
);

  localparam int W  = RECV_BYTES_QTD * 8;
  localparam int CW = $clog2(RECV_BYTES_QTD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RECV_BYTES_QTD - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  buf_q, buf_d;
  logic          pronto_q, pronto_d;
  logic          tout_q, tout_d;
  logic [W-1:0]  shift_nx;
  logic          timer_clear, timer_en, timer_expired;

  payload_receiver_inter_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  assign shift_nx = (shift_q << 8) | W'(rx.dado_recebido);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    pronto_d    = 1'b0;
    tout_d      = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx.dado_valido && (rx.dado_recebido == EVENT_CODE)) begin
          state_d     = ST_RECEIVING;
          cnt_d       = '0;
          timer_clear = 1'b1;
        end
      end
      ST_RECEIVING: begin
        // A strobe always beats a coincident timer expiry.
        if (rx.dado_valido) begin
          timer_clear = 1'b1;
          shift_d     = shift_nx;
          if (cnt_q == CNT_LAST) begin
            buf_d    = shift_nx;
            pronto_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            tout_d      = 1'b1;
            cnt_d       = '0;
            timer_clear = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      buf_q    <= '0;
      pronto_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      buf_q    <= buf_d;
      pronto_q <= pronto_d;
      tout_q   <= tout_d;
    end
  end

  assign rx.buffer_recebido = buf_q;
  assign rx.pacote_pronto   = pronto_q;
  assign rx.erro_timeout    = tout_q;
  assign rx.ocupado         = (state_q == ST_RECEIVING);

endmodule

// File: doc/payload_receiver.md
# payload_receiver

Inbound counterpart of the outbound payload path: watches the byte stream from the UART receiver, waits for a configured event-code header byte, then collects a fixed number of payload bytes into a parallel buffer. Sits between the UART RX core and the game-logic command decoders. One instance per inbound event code. A partial packet is discarded if the inter-byte gap exceeds a timeout.

## Interface
- EVENT_CODE, 8'hC1, header byte that opens a packet
- RECV_BYTES_QTD, 4, payload bytes after the header (≥1)
- TIMEOUT_CYCLES, 50000, max clock cycles allowed between consecutive bytes of one packet (≥2)

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- dado_recebido  in  8  byte from UART RX, valid only when dado_valido=1
- dado_valido  in  1  1-cycle strobe per received byte
- buffer_recebido  out  RECV_BYTES_QTD*8  last complete payload; first payload byte in the MSBs
- pacote_pronto  out  1  1-cycle pulse: buffer_recebido just updated
- erro_timeout  out  1  1-cycle pulse: partial packet discarded
- ocupado  out  1  high while in RECEIVING

## Operation
- States: IDLE, RECEIVING.
- IDLE: a strobed byte equal to EVENT_CODE moves to RECEIVING, byte counter=0, timer=0. Other bytes are ignored. No output pulse.
- RECEIVING, strobed byte: shift it into the internal shift register (shift left by 8, new byte in LSBs), counter+1, timer=0. Any value counts as data, including EVENT_CODE.
- When the strobed byte is byte RECV_BYTES_QTD (counter==RECV_BYTES_QTD-1):
  - Load buffer_recebido with the full assembled word, including that byte.
  - Pulse pacote_pronto.
  - Return to IDLE.
- RECEIVING, no strobe: timer+1. At timer==TIMEOUT_CYCLES-1 without a strobe:
  - Pulse erro_timeout, return to IDLE, clear counter.
  - buffer_recebido is unchanged.
- A strobe in the same cycle the timer expires wins: the byte is accepted and there is no timeout.
- buffer_recebido only changes on packet completion. Partial data is never visible.
- Counter width $clog2(RECV_BYTES_QTD+1). Timer width $clog2(TIMEOUT_CYCLES+1). The timer saturates and never wraps.
- Reset values:
  - All outputs 0, buffer_recebido all-zero.
  - State IDLE, counter and timer 0, shift register 0.
- Reset asserted mid-packet: immediate return to IDLE. The partial packet is lost, with no pulse.

## Timing
- All outputs are registered.
- Final payload byte sampled at edge k: buffer_recebido holds the new value and pacote_pronto=1 for exactly the cycle after edge k.
- ocupado goes high the cycle after the header edge and low the cycle after the completion or timeout edge.
- Back-to-back: a header strobed on the cycle right after completion is accepted. There are no dead cycles.
- Timeout fires TIMEOUT_CYCLES cycles after the last accepted strobe edge. erro_timeout is high for one cycle.
- pacote_pronto and erro_timeout are never high together.
- Strobes are at most one per cycle. Consecutive-cycle strobes are fully supported.

## Structure
- Shared package/include holds the event-code constants: EVENT_GAME_STATUS=8'hAD plus the inbound command codes (e.g. 8'hC1). Instances take EVENT_CODE from there.
- One natural sub-module, inter_byte_timer:
  - Parameter: TIMEOUT_CYCLES.
  - Inputs: clear, enable.
  - Output: expired pulse.
  - Instantiated once.
- FSM, counter and shift register stay in the top.

## Test plan
(RECV_BYTES_QTD=4, EVENT_CODE=8'hC1, TIMEOUT_CYCLES=16)
- Reset release, then strobe C1,11,22,33,44 spaced 3 cycles → one pacote_pronto pulse, buffer_recebido=32'h11223344, ocupado low afterwards.
- Bytes 55,AA before C1,01,02,03,04 → 55/AA ignored, buffer=32'h01020304. Payload C1,C1,C1,C1 → buffer=32'hC1C1C1C1.
- C1,12,34 then 16 idle cycles → erro_timeout pulse on the 16th cycle after the 34 edge, no pacote_pronto, buffer keeps the previous value. Then C1,A1,A2,A3,A4 → buffer=32'hA1A2A3A4.
- Byte strobed exactly on the cycle the timer would expire → accepted, no erro_timeout. The packet completes normally.
- Two packets strobed every cycle (10 consecutive strobes) → two pacote_pronto pulses 5 cycles apart, final buffer equal to the second payload.
- reset pulled low after C1,77 then released, then 88,99,AA,BB → no pulse at all. 88 is not a header.
